mem_arbiter: RTL and testbench

- Two-requester round-robin arbiter and sequencer in front of the single-port 32x256 synchronous memory.
- Accepts one read or write command at a time from port 0 or port 1 and drives the memory valid/write-enable/address/data handshake.
- Waits for the memory's registered ready, then returns read data and a completion pulse to the granted requester.
- A watchdog flags a memory that never answers.

---
 rtl/mem_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_arbiter.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Two-requester round-robin arbiter and sequencer in front of a single-port
//   synchronous memory. Accepts one read or write command at a time, issues
//   it to the memory as a one-cycle valid, waits for the memory's registered
//   ready and returns a one-cycle done pulse, plus read data for reads, to the
//   requester that won. A watchdog ends a transaction with err_o=1 when the
//   memory never answers.
//
//   Ports
//     clk_i, rst_ni                 clock, async active-low reset
//     pN_valid_i/we_i/addr_i/wdata_i  requester N command (N = 0, 1)
//     pN_gnt_o                      command accepted (combinational pulse)
//     pN_done_o                     transaction complete (registered pulse)
//     rdata_o, err_o                read data / timeout flag, valid with done
//     busy_o                        sequencer not idle
//     mem_valid_o/we_o/addr_o/wdata_o  memory request side
//     mem_ready_i, mem_rdata_i      memory response side
//
//   state | meaning
//   IDLE  | waiting for a request; grant is decided combinationally here
//   ISSUE | mem_valid_o high for one cycle with the latched command
//   WAIT  | waiting for mem_ready_i, watchdog counting
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int WIDTH = 32,
    parameter int ADDRE = 8,
    parameter int TMO   = 15
) (
    input  logic             clk_i,
    input  logic             rst_ni,

    input  logic             p0_valid_i,
    input  logic             p0_we_i,
    input  logic [ADDRE-1:0] p0_addr_i,
    input  logic [WIDTH-1:0] p0_wdata_i,
    output logic             p0_gnt_o,
    output logic             p0_done_o,

    input  logic             p1_valid_i,
    input  logic             p1_we_i,
    input  logic [ADDRE-1:0] p1_addr_i,
    input  logic [WIDTH-1:0] p1_wdata_i,
    output logic             p1_gnt_o,
    output logic             p1_done_o,

    output logic [WIDTH-1:0] rdata_o,
    output logic             err_o,
    output logic             busy_o,

    output logic             mem_valid_o,
    output logic             mem_we_o,
    output logic [ADDRE-1:0] mem_addr_o,
    output logic [WIDTH-1:0] mem_wdata_o,
    input  logic             mem_ready_i,
    input  logic [WIDTH-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [7:0] TMO_LIM = 8'(TMO);

    state_t     state;
    logic       last_gnt;
    logic       gnt_sel;
    logic       req_any;
    logic [7:0] tmo_cnt;

    // Winner select: a lone requester always wins; under contention the port
    // that was not granted last time wins.
    always_comb begin
        req_any = p0_valid_i | p1_valid_i;
        if (p0_valid_i && p1_valid_i) begin
            gnt_sel = ~last_gnt;
        end else begin
            gnt_sel = p1_valid_i;
        end
    end

    // Grant is qualified with reset so every output reads 0 while held in reset.
    assign p0_gnt_o = rst_ni & (state == IDLE) & req_any & ~gnt_sel;
    assign p1_gnt_o = rst_ni & (state == IDLE) & req_any &  gnt_sel;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            last_gnt    <= 1'b1;
            tmo_cnt     <= 8'd0;
            p0_done_o   <= 1'b0;
            p1_done_o   <= 1'b0;
            rdata_o     <= '0;
            err_o       <= 1'b0;
            busy_o      <= 1'b0;
            mem_valid_o <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else begin
            p0_done_o   <= 1'b0;
            p1_done_o   <= 1'b0;
            err_o       <= 1'b0;
            mem_valid_o <= 1'b0;

            case (state)
                IDLE: begin
                    if (req_any) begin
                        last_gnt    <= gnt_sel;
                        mem_we_o    <= gnt_sel ? p1_we_i    : p0_we_i;
                        mem_addr_o  <= gnt_sel ? p1_addr_i  : p0_addr_i;
                        mem_wdata_o <= gnt_sel ? p1_wdata_i : p0_wdata_i;
                        mem_valid_o <= 1'b1;
                        busy_o      <= 1'b1;
                        state       <= ISSUE;
                    end
                end

                ISSUE: begin
                    tmo_cnt <= 8'd0;
                    state   <= WAIT;
                end

                WAIT: begin
                    if (mem_ready_i) begin
                        p0_done_o <= ~last_gnt;
                        p1_done_o <=  last_gnt;
                        if (!mem_we_o) begin
                            rdata_o <= mem_rdata_i;
                        end
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end else if (tmo_cnt + 8'd1 == TMO_LIM) begin
                        // TMO-th consecutive WAIT cycle without ready.
                        p0_done_o <= ~last_gnt;
                        p1_done_o <=  last_gnt;
                        err_o     <= 1'b1;
                        tmo_cnt   <= 8'd0;
                        busy_o    <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end

                default: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Bench for mem_arbiter: a behavioural memory with configurable response
//   latency, a transaction-level reference model that predicts grants, the
//   issued command, busy and the done/err/rdata result, directed scenarios and
//   a randomized two-port traffic phase.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int WIDTH = 32;
    localparam int ADDRE = 8;
    localparam int TMO   = 15;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic             p0_valid_i = 1'b0, p0_we_i = 1'b0;
    logic [ADDRE-1:0] p0_addr_i = '0;
    logic [WIDTH-1:0] p0_wdata_i = '0;
    logic             p1_valid_i = 1'b0, p1_we_i = 1'b0;
    logic [ADDRE-1:0] p1_addr_i = '0;
    logic [WIDTH-1:0] p1_wdata_i = '0;
    logic             p0_gnt_o, p0_done_o, p1_gnt_o, p1_done_o;
    logic [WIDTH-1:0] rdata_o;
    logic             err_o, busy_o;
    logic             mem_valid_o, mem_we_o;
    logic [ADDRE-1:0] mem_addr_o;
    logic [WIDTH-1:0] mem_wdata_o;
    logic             mem_ready_i = 1'b0;
    logic [WIDTH-1:0] mem_rdata_i = '0;

    mem_arbiter #(.WIDTH(WIDTH), .ADDRE(ADDRE), .TMO(TMO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .p0_valid_i(p0_valid_i), .p0_we_i(p0_we_i), .p0_addr_i(p0_addr_i),
        .p0_wdata_i(p0_wdata_i), .p0_gnt_o(p0_gnt_o), .p0_done_o(p0_done_o),
        .p1_valid_i(p1_valid_i), .p1_we_i(p1_we_i), .p1_addr_i(p1_addr_i),
        .p1_wdata_i(p1_wdata_i), .p1_gnt_o(p1_gnt_o), .p1_done_o(p1_done_o),
        .rdata_o(rdata_o), .err_o(err_o), .busy_o(busy_o),
        .mem_valid_o(mem_valid_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;
    int tcyc = 0;

    initial forever begin
        @(posedge clk_i);
        tcyc++;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, tcyc);
        end
    endtask

    // Memory behaviour and reference-model state
    logic [WIDTH-1:0] mem_arr [256];
    logic [WIDTH-1:0] exp_mem [256];
    bit               mem_resp_en = 1'b1;
    bit               rand_lat = 1'b0;
    int               mem_lat = 1;

    bit               last_m = 1'b1;
    bit               act = 1'b0;
    int               t_gnt = 0, t_done = 0;
    bit               c_port, c_we, c_err;
    logic [ADDRE-1:0] c_addr;
    logic [WIDTH-1:0] c_wdata;
    logic [WIDTH-1:0] rdata_m = '0;

    task automatic model_reset();
        last_m  = 1'b1;
        act     = 1'b0;
        rdata_m = '0;
    endtask

    // Memory: sees valid at a clock edge, answers with ready mem_lat cycles later.
    initial begin : memory
        bit sv, swe, pend;
        logic [ADDRE-1:0] sa;
        logic [WIDTH-1:0] sd, mdata;
        int mcnt;
        pend = 0;
        mcnt = 0;
        mdata = '0;
        forever begin
            @(negedge clk_i);
            sv = mem_valid_o; swe = mem_we_o; sa = mem_addr_o; sd = mem_wdata_o;
            @(posedge clk_i);
            #1;
            mem_ready_i = 1'b0;
            if (!rst_ni) begin
                pend = 0;
            end else if (sv) begin
                if (swe) mem_arr[sa] = sd;
                mdata = mem_arr[sa];
                if (mem_resp_en) begin
                    if (mem_lat <= 1) begin
                        mem_ready_i = 1'b1;
                        mem_rdata_i = mdata;
                    end else begin
                        mcnt = mem_lat - 1;
                        pend = 1;
                    end
                end
            end else if (pend) begin
                if (mcnt == 1) begin
                    mem_ready_i = 1'b1;
                    mem_rdata_i = mdata;
                    pend = 0;
                end else begin
                    mcnt--;
                end
            end
        end
    end

    // Reference model: one transaction in flight; grant to the lone requester
    // or, under contention, to the port not served last; issue one cycle after
    // grant; done lat+2 cycles after grant, or TMO+2 on a silent memory.
    initial begin : monitor
        logic [1:0] exp_g, exp_d;
        bit w, exp_v, exp_busy;
        forever begin
            @(negedge clk_i);
            if (rst_ni) begin
                exp_v = act && (tcyc == t_gnt + 1);
                if (exp_v || mem_valid_o) begin
                    check_val("mem_valid", mem_valid_o, exp_v);
                    if (exp_v) begin
                        check_val("mem_we", mem_we_o, c_we);
                        check_val("mem_addr", mem_addr_o, c_addr);
                        check_val("mem_wdata", mem_wdata_o, c_wdata);
                    end
                end
                if (act && tcyc > t_gnt + 1 && tcyc < t_done)
                    check_val("wait_addr_hold", mem_addr_o, c_addr);
                exp_busy = act && tcyc > t_gnt && tcyc < t_done;
                check_val("busy", busy_o, exp_busy);

                exp_d = 2'b00;
                if (act && tcyc == t_done) exp_d = c_port ? 2'b10 : 2'b01;
                if (exp_d != 2'b00 || p0_done_o || p1_done_o || err_o) begin
                    check_val("done_port", {p1_done_o, p0_done_o}, exp_d);
                    if (exp_d != 2'b00) begin
                        if (!c_err) begin
                            if (c_we) exp_mem[c_addr] = c_wdata;
                            else      rdata_m = exp_mem[c_addr];
                        end
                        check_val("done_err", err_o, c_err);
                        check_val("done_rdata", rdata_o, rdata_m);
                        act = 1'b0;
                    end else begin
                        check_val("stray_err", err_o, 1'b0);
                    end
                end

                exp_g = 2'b00;
                w = 1'b0;
                if (!act && (p0_valid_i || p1_valid_i)) begin
                    w = (p0_valid_i && p1_valid_i) ? ~last_m : p1_valid_i;
                    exp_g = w ? 2'b10 : 2'b01;
                end
                if (exp_g != 2'b00 || p0_gnt_o || p1_gnt_o)
                    check_val("gnt_port", {p1_gnt_o, p0_gnt_o}, exp_g);
                if (exp_g != 2'b00) begin
                    last_m  = w;
                    act     = 1'b1;
                    t_gnt   = tcyc;
                    c_port  = w;
                    c_we    = w ? p1_we_i    : p0_we_i;
                    c_addr  = w ? p1_addr_i  : p0_addr_i;
                    c_wdata = w ? p1_wdata_i : p0_wdata_i;
                    mem_lat = rand_lat ? int'($urandom_range(1, 4)) : 1;
                    c_err   = !mem_resp_en;
                    t_done  = c_err ? tcyc + TMO + 2 : tcyc + 2 + mem_lat;
                end
            end
        end
    end

    // Issue one command on port p and wait for its done; returns at posedge+1.
    task automatic do_cmd(input bit p, input bit we, input logic [ADDRE-1:0] a,
                          input logic [WIDTH-1:0] d, output logic [WIDTH-1:0] rd,
                          output bit er, output int gc, output int dc);
        bit got;
        int n;
        rd = '0; er = 1'b0; gc = 0; dc = 0;
        if (p) begin p1_we_i = we; p1_addr_i = a; p1_wdata_i = d; p1_valid_i = 1'b1; end
        else   begin p0_we_i = we; p0_addr_i = a; p0_wdata_i = d; p0_valid_i = 1'b1; end
        got = 1'b0;
        n = 0;
        while (!got && n < 50) begin
            @(negedge clk_i);
            n++;
            got = p ? p1_gnt_o : p0_gnt_o;
            gc = tcyc;
            @(posedge clk_i);
            #1;
        end
        if (p) p1_valid_i = 1'b0; else p0_valid_i = 1'b0;
        if (!got) begin
            check_val("gnt_timeout", 0, 1);
            return;
        end
        got = 1'b0;
        n = 0;
        while (!got && n < 50) begin
            @(negedge clk_i);
            n++;
            if (p ? p1_done_o : p0_done_o) begin
                got = 1'b1; rd = rdata_o; er = err_o; dc = tcyc;
            end
            @(posedge clk_i);
            #1;
        end
        if (!got) check_val("done_timeout", 0, 1);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    initial begin : main
        logic [WIDTH-1:0] rd;
        bit er, g0, g1, got;
        int gc, dc, n0, n1, guard;
        int ord[$];
        int gl[$];
        bit coinc[$];

        for (int i = 0; i < 256; i++) begin
            mem_arr[i] = '0;
            exp_mem[i] = '0;
        end

        rst_ni = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check_val("rst_ctrl", {busy_o, mem_valid_o, mem_we_o, p0_done_o, p1_done_o, err_o,
                               p0_gnt_o, p1_gnt_o}, 8'h00);
        check_val("rst_addr", mem_addr_o, 0);
        check_val("rst_data", {rdata_o, mem_wdata_o}, 64'h0);
        rst_ni = 1'b1;

        // Write 0xDEADBEEF to 0x05 then read it back on port 0.
        do_cmd(1'b0, 1'b1, 8'h05, 32'hDEADBEEF, rd, er, gc, dc);
        do_cmd(1'b0, 1'b0, 8'h05, 32'h0, rd, er, gc, dc);
        check_val("p0_read_data", rd, 32'hDEADBEEF);
        check_val("p0_read_err", er, 1'b0);
        check_val("p0_read_latency", dc - gc, 3);

        // Write then read back 0xFF on port 1.
        do_cmd(1'b1, 1'b1, 8'hFF, 32'h12345678, rd, er, gc, dc);
        check_val("p1_write_err", er, 1'b0);
        do_cmd(1'b1, 1'b0, 8'hFF, 32'h0, rd, er, gc, dc);
        check_val("p1_readback", rd, 32'h12345678);

        // Timeout on a silent memory, then normal completion again.
        mem_resp_en = 1'b0;
        do_cmd(1'b0, 1'b0, 8'h05, 32'h0, rd, er, gc, dc);
        check_val("tmo_err", er, 1'b1);
        check_val("tmo_rdata_kept", rd, 32'h12345678);
        check_val("tmo_latency", dc - gc, TMO + 2);
        mem_resp_en = 1'b1;
        do_cmd(1'b0, 1'b0, 8'h05, 32'h0, rd, er, gc, dc);
        check_val("post_tmo_err", er, 1'b0);
        check_val("post_tmo_rdata", rd, 32'hDEADBEEF);

        // Contention: both ports hold valid for three commands each.
        do_reset();
        p0_we_i = 1'b0; p0_addr_i = 8'($urandom_range(0, 7)); p0_valid_i = 1'b1;
        p1_we_i = 1'b0; p1_addr_i = 8'($urandom_range(0, 7)); p1_valid_i = 1'b1;
        n0 = 0; n1 = 0; guard = 0;
        while ((n0 < 3 || n1 < 3) && guard < 60) begin
            @(negedge clk_i);
            guard++;
            g0 = p0_gnt_o;
            g1 = p1_gnt_o;
            if (g0) begin ord.push_back(0); n0++; end
            if (g1) begin ord.push_back(1); n1++; end
            @(posedge clk_i);
            #1;
            if (g0) begin p0_addr_i = 8'($urandom_range(0, 7)); if (n0 == 3) p0_valid_i = 1'b0; end
            if (g1) begin p1_addr_i = 8'($urandom_range(0, 7)); if (n1 == 3) p1_valid_i = 1'b0; end
        end
        p0_valid_i = 1'b0;
        p1_valid_i = 1'b0;
        check_val("contention_count", ord.size(), 6);
        for (int i = 0; i < ord.size() && i < 6; i++)
            check_val("contention_order", ord[i], i % 2);
        repeat (6) @(posedge clk_i);
        #1;

        // Asynchronous reset while waiting on the memory.
        mem_resp_en = 1'b0;
        p0_we_i = 1'b0; p0_addr_i = 8'h33; p0_valid_i = 1'b1;
        got = 1'b0; guard = 0;
        while (!got && guard < 20) begin
            @(negedge clk_i);
            guard++;
            got = p0_gnt_o;
            @(posedge clk_i);
            #1;
        end
        p0_valid_i = 1'b0;
        check_val("rstw_gnt_seen", got, 1'b1);
        @(negedge clk_i);
        @(negedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        check_val("rstw_ctrl", {busy_o, mem_valid_o, mem_we_o, p0_done_o, p1_done_o, err_o}, 6'h00);
        check_val("rstw_addr", mem_addr_o, 0);
        model_reset();
        mem_resp_en = 1'b1;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        repeat (4) @(posedge clk_i);
        #1;
        p0_we_i = 1'b0; p0_addr_i = 8'h01; p0_valid_i = 1'b1;
        p1_we_i = 1'b0; p1_addr_i = 8'h02; p1_valid_i = 1'b1;
        @(negedge clk_i);
        check_val("rstw_first_gnt", {p1_gnt_o, p0_gnt_o}, 2'b01);
        @(posedge clk_i);
        #1;
        p0_valid_i = 1'b0;
        p1_valid_i = 1'b0;
        repeat (6) @(posedge clk_i);
        #1;

        // Back-to-back commands on port 1 alone.
        p1_we_i = 1'b0; p1_addr_i = 8'($urandom_range(0, 7)); p1_valid_i = 1'b1;
        guard = 0;
        while (gl.size() < 4 && guard < 60) begin
            @(negedge clk_i);
            guard++;
            g1 = p1_gnt_o;
            if (g1) begin gl.push_back(tcyc); coinc.push_back(p1_done_o); end
            @(posedge clk_i);
            #1;
            if (g1) begin
                p1_addr_i = 8'($urandom_range(0, 7));
                if (gl.size() == 4) p1_valid_i = 1'b0;
            end
        end
        p1_valid_i = 1'b0;
        check_val("b2b_count", gl.size(), 4);
        for (int i = 1; i < gl.size(); i++) begin
            check_val("b2b_spacing", gl[i] - gl[i-1], 3);
            check_val("b2b_gnt_with_done", coinc[i], 1'b1);
        end
        repeat (6) @(posedge clk_i);
        #1;

        // Randomized two-port traffic with variable memory latency.
        rand_lat = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk_i);
            g0 = p0_gnt_o;
            g1 = p1_gnt_o;
            @(posedge clk_i);
            #1;
            if (g0) p0_valid_i = 1'b0;
            if (g1) p1_valid_i = 1'b0;
            if (!p0_valid_i && $urandom_range(0, 1) == 1) begin
                p0_we_i = 1'($urandom_range(0, 1)); p0_addr_i = 8'($urandom_range(0, 7));
                p0_wdata_i = $urandom; p0_valid_i = 1'b1;
            end
            if (!p1_valid_i && $urandom_range(0, 1) == 1) begin
                p1_we_i = 1'($urandom_range(0, 1)); p1_addr_i = 8'($urandom_range(0, 7));
                p1_wdata_i = $urandom; p1_valid_i = 1'b1;
            end
        end
        p0_valid_i = 1'b0;
        p1_valid_i = 1'b0;
        repeat (12) @(posedge clk_i);
        #1;
        check_val("drain_idle", {busy_o, act}, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
